// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-style datapath: one instruction per handshake, executed over
// DECODE/EXECUTE/MEM/WB with an internal register file and data memory.
module multicycle_datapath #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_DEPTH = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  input  logic              RegDst,
  input  logic              MemRead,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic [3:0]        ALUCtrl,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXECUTE,
    MEM,
    WB
  } state_t;

  state_t state;
  state_t state_next;

  logic [25:0]       instr_q;
  logic              reg_dst_q;
  logic              mem_read_q;
  logic              mem_to_reg_q;
  logic              mem_write_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic [3:0]        alu_ctrl_q;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] mdr_q;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic signed [15:0] imm16;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              slt_flag;
  logic              sltu_flag;
  logic [4:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              wb_enable;
  logic [MEM_AW-1:0] mem_idx;

  // $0 and unimplemented indices read as zero
  function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx != 5'd0 && {1'b0, idx} < REG_LIMIT) begin
      val = regs[idx[REG_AW-1:0]];
    end
    return val;
  endfunction

  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign imm16    = instr_q[15:0];
  assign imm_ext  = DATA_W'(imm16);
  assign mem_idx  = result[MEM_AW-1:0];
  assign dbg_data = read_reg(dbg_addr);

  assign wb_dest   = reg_dst_q ? rd : rt;
  assign wb_data   = mem_to_reg_q ? mdr_q : result;
  assign wb_enable = (state == WB) && reg_write_q && (wb_dest != 5'd0) &&
                     ({1'b0, wb_dest} < REG_LIMIT);

  assign instr_ready = (state == IDLE);

  always_comb begin
    alu_b     = alu_src_q ? imm_q : b_q;
    slt_flag  = $signed(a_q) < $signed(alu_b);
    sltu_flag = a_q < alu_b;
    alu_out   = '0;
    case (alu_ctrl_q)
      4'b0000: alu_out = a_q & alu_b;
      4'b0001: alu_out = a_q | alu_b;
      4'b0010: alu_out = a_q + alu_b;
      4'b0110: alu_out = a_q - alu_b;
      4'b0111: alu_out = DATA_W'(slt_flag);
      4'b0011: alu_out = DATA_W'(sltu_flag);
      4'b1100: alu_out = ~(a_q | alu_b);
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_next = DECODE;
        end
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        if (mem_read_q || mem_write_q) begin
          state_next = MEM;
        end else if (reg_write_q) begin
          state_next = WB;
        end else begin
          state_next = IDLE;
        end
      end
      MEM:     state_next = reg_write_q ? WB : IDLE;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // done marks the first IDLE cycle after any final state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      result       <= '0;
      zero         <= 1'b1;
      instr_q      <= '0;
      reg_dst_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_ctrl_q   <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      mdr_q        <= '0;
    end else begin
      state <= state_next;
      done  <= (state != IDLE) && (state_next == IDLE);
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q      <= instruction[25:0];
            reg_dst_q    <= RegDst;
            mem_read_q   <= MemRead;
            mem_to_reg_q <= MemtoReg;
            mem_write_q  <= MemWrite;
            alu_src_q    <= ALUSrc;
            reg_write_q  <= RegWrite;
            alu_ctrl_q   <= ALUCtrl;
          end
        end
        DECODE: begin
          a_q   <= read_reg(rs);
          b_q   <= read_reg(rt);
          imm_q <= imm_ext;
        end
        EXECUTE: begin
          result <= alu_out;
          zero   <= (alu_out == '0);
        end
        MEM: begin
          if (mem_read_q) begin
            mdr_q <= mem[mem_idx];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_enable) begin
      regs[wb_dest[REG_AW-1:0]] <= wb_data;
    end
  end

  // Memory has no reset, but a reset edge still suppresses an in-flight store
  always_ff @(posedge clk) begin
    if (!reset && state == MEM && mem_write_q) begin
      mem[mem_idx] <= b_q;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: hand-computed register, flag and
// latency expectations for ALU, load/store, reset abort and back-to-back issue.
`timescale 1ns/1ps
module tb_multicycle_datapath;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic              RegDst;
  logic              MemRead;
  logic              MemtoReg;
  logic              MemWrite;
  logic              ALUSrc;
  logic              RegWrite;
  logic [3:0]        ALUCtrl;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic [4:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int err_count   = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(
    .DATA_W(DATA_W),
    .NUM_REGS(32),
    .MEM_DEPTH(128)
  ) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instruction(instruction),
    .RegDst(RegDst),
    .MemRead(MemRead),
    .MemtoReg(MemtoReg),
    .MemWrite(MemWrite),
    .ALUSrc(ALUSrc),
    .RegWrite(RegWrite),
    .ALUCtrl(ALUCtrl),
    .done(done),
    .result(result),
    .zero(zero),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input logic [4:0] idx, input logic [31:0] expected);
    dbg_addr = idx;
    #1;
    checkOutput(tag, dbg_data, expected);
  endtask

  task automatic setCtrl(input logic rdst, input logic mrd, input logic m2r,
                         input logic mwr, input logic asrc, input logic rwr,
                         input logic [3:0] alu);
    RegDst   = rdst;
    MemRead  = mrd;
    MemtoReg = m2r;
    MemWrite = mwr;
    ALUSrc   = asrc;
    RegWrite = rwr;
    ALUCtrl  = alu;
  endtask

  // Starts and ends at a falling edge; ends in the done cycle
  task automatic applyStimulus(input string tag, input logic [31:0] ins,
                               input logic rdst, input logic mrd, input logic m2r,
                               input logic mwr, input logic asrc, input logic rwr,
                               input logic [3:0] alu, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instruction = ins;
    setCtrl(rdst, mrd, m2r, mwr, asrc, rwr, alu);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = 32'hFFFF_FFFF;
    setCtrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int done_seen;
    int k;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    dbg_addr    = '0;
    setCtrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);
    checkReg("rst_r1", 5'd1, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Immediate and register ALU ops
    applyStimulus("addi_r1", 32'h2001_0005, 0, 0, 0, 0, 1, 1, 4'b0010, 4);
    checkReg("addi_r1_val", 5'd1, 32'd5);
    checkOutput("addi_result", result, 32'd5);
    checkOutput("addi_zero", 32'(zero), 32'd0);
    applyStimulus("addi_r2", 32'h2002_0007, 0, 0, 0, 0, 1, 1, 4'b0010, 4);
    applyStimulus("add_r3", 32'h0022_1820, 1, 0, 0, 0, 0, 1, 4'b0010, 4);
    checkReg("add_r3_val", 5'd3, 32'd12);
    applyStimulus("sub_r3", 32'h0022_1820, 1, 0, 0, 0, 0, 1, 4'b0110, 4);
    checkReg("sub_r3_val", 5'd3, 32'hFFFF_FFFE);
    checkOutput("sub_zero", 32'(zero), 32'd0);

    // Store then load back through memory word 4
    applyStimulus("sw", 32'hAC03_0004, 0, 0, 0, 1, 1, 0, 4'b0010, 4);
    applyStimulus("lw", 32'h8C04_0004, 0, 1, 1, 0, 1, 1, 4'b0010, 5);
    checkReg("lw_r4_val", 5'd4, 32'hFFFF_FFFE);

    // Signed versus unsigned compare and logic ops
    applyStimulus("addi_m1", 32'h2001_FFFF, 0, 0, 0, 0, 1, 1, 4'b0010, 4);
    applyStimulus("addi_one", 32'h2002_0001, 0, 0, 0, 0, 1, 1, 4'b0010, 4);
    checkReg("r1_m1", 5'd1, 32'hFFFF_FFFF);
    applyStimulus("slt", 32'h0022_2820, 1, 0, 0, 0, 0, 1, 4'b0111, 4);
    checkReg("slt_r5", 5'd5, 32'd1);
    applyStimulus("sltu", 32'h0022_3020, 1, 0, 0, 0, 0, 1, 4'b0011, 4);
    checkReg("sltu_r6", 5'd6, 32'd0);
    checkOutput("sltu_zero", 32'(zero), 32'd1);
    applyStimulus("or", 32'h0022_3820, 1, 0, 0, 0, 0, 1, 4'b0001, 4);
    checkReg("or_r7", 5'd7, 32'hFFFF_FFFF);
    applyStimulus("nor", 32'h0022_4820, 1, 0, 0, 0, 0, 1, 4'b1100, 4);
    checkOutput("nor_result", result, 32'd0);
    checkOutput("nor_zero", 32'(zero), 32'd1);
    applyStimulus("and", 32'h0022_4020, 1, 0, 0, 0, 0, 1, 4'b0000, 4);
    checkReg("and_r8", 5'd8, 32'd1);
    applyStimulus("badop", 32'h0022_1820, 1, 0, 0, 0, 0, 0, 4'b1111, 3);
    checkOutput("badop_result", result, 32'd0);
    checkOutput("badop_zero", 32'(zero), 32'd1);
    checkReg("badop_r3_kept", 5'd3, 32'hFFFF_FFFE);

    // Read and write the same word: MDR keeps the old data
    applyStimulus("rmw", 32'h8C01_0004, 0, 1, 1, 1, 1, 1, 4'b0010, 5);
    checkReg("rmw_r1_old", 5'd1, 32'hFFFF_FFFE);
    applyStimulus("lw_wrap", 32'h8C0A_0084, 0, 1, 1, 0, 1, 1, 4'b0010, 5);
    checkReg("lw_wrap_r10", 5'd10, 32'hFFFF_FFFF);
    checkOutput("lw_wrap_result", result, 32'h0000_0084);

    // Writes to $0 are dropped
    applyStimulus("addi_r0", 32'h2000_0009, 0, 0, 0, 0, 1, 1, 4'b0010, 4);
    checkReg("r0_zero", 5'd0, 32'd0);
    checkOutput("addi_r0_result", result, 32'd9);

    // Reset during EXECUTE of a register-writing op
    instruction = 32'h2005_0055;
    setCtrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 32'(instr_ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", result, 32'd0);
    checkReg("abort_r5", 5'd5, 32'd0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    checkReg("abort_r5_later", 5'd5, 32'd0);

    // instr_valid held high; busy-cycle control changes must be ignored
    @(negedge clk);
    k = 0;
    for (int c = 0; c <= 12; c++) begin
      checkOutput($sformatf("b2b_ready_c%0d", c), 32'(instr_ready), 32'(c % 4 == 0));
      if (c > 0 && c % 4 == 0) begin
        checkOutput($sformatf("b2b_done_c%0d", c), 32'(done), 32'd1);
      end
      if (instr_ready && k < 3) begin
        case (k)
          0: begin
            instruction = 32'h2001_0001;
            setCtrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
          end
          1: begin
            instruction = 32'h2022_0002;
            setCtrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
          end
          default: begin
            instruction = 32'h0022_1820;
            setCtrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010);
          end
        endcase
        instr_valid = 1'b1;
        k++;
      end else if (instr_ready) begin
        instr_valid = 1'b0;
      end else begin
        instruction = $urandom;
        setCtrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 4'($urandom));
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    checkReg("b2b_r1", 5'd1, 32'd1);
    checkReg("b2b_r2", 5'd2, 32'd3);
    checkReg("b2b_r3", 5'd3, 32'd4);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
